// File: rtl/coef_commit_sequencer.sv
// Shadows offset/weight/DSP coefficients and replays dirty entries to PCIe_packet_gen as one burst aligned to a word-sync edge.
// Latency: burst starts 3 cycles after word_sync_n falls; 1+SETUP+WR_HOLD cycles per entry; no backpressure, abort cancels.
module coef_commit_sequencer #(
  parameter int NBANK   = 3,
  parameter int NCH     = 6,
  parameter int SETUP   = 2,
  parameter int WR_HOLD = 2
) (
  input  logic        trn_clk,
  input  logic        pio_reset_n,
  input  logic        host_wr_en,
  input  logic [4:0]  host_addr,
  input  logic [31:0] host_wdata,
  input  logic        commit,
  input  logic        abort,
  input  logic        word_sync_n,
  output logic [15:0] reg_offset,
  output logic [31:0] reg_data,
  output logic        reg_wrt_en,
  output logic        busy,
  output logic        done,
  output logic        addr_err,
  output logic [4:0]  pending
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_SCAN, S_SETUP, S_STROBE, S_DONE
  } state_t;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(WR_HOLD - 1);

  state_t      state_q, state_d;
  logic [31:0] shadow_q [32];
  logic [31:0] dirty_q, dirty_d;
  logic [31:0] work_q, work_d;
  logic [31:0] cur_bit;
  logic [4:0]  cur_q, cur_d;
  logic [4:0]  pick;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] off_q, off_d;
  logic [31:0] dat_q, dat_d;
  logic        err_q, err_d;
  logic [4:0]  pend_q, pend_d;
  logic [5:0]  pop;
  logic        sync1_q, sync2_q, sync3_q;
  logic        sync_edge, addr_ok, abort_hit, commit_ok;

  assign sync_edge = sync3_q & ~sync2_q;
  assign addr_ok   = (int'(host_addr[4:3]) < NBANK) && (int'(host_addr[2:0]) < NCH);
  assign abort_hit = abort && (state_q != S_IDLE);
  assign commit_ok = commit && !abort && (state_q == S_IDLE);
  assign cur_bit   = (state_q == S_SETUP || state_q == S_STROBE) ? (32'd1 << cur_q) : 32'd0;

  // sync3_q only feeds edge detection; it is not part of the metastability chain
  always_ff @(posedge trn_clk or negedge pio_reset_n) begin
    if (!pio_reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= word_sync_n;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  always_ff @(posedge trn_clk or negedge pio_reset_n) begin
    if (!pio_reset_n) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort_hit) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (commit_ok) state_d = S_ARMED;
        S_ARMED:  if (sync_edge) state_d = S_SCAN;
        S_SCAN:   state_d = (work_q == 32'd0) ? S_DONE : S_SETUP;
        S_SETUP:  if (cnt_q == SETUP_LAST) state_d = S_STROBE;
        S_STROBE: if (cnt_q == HOLD_LAST) state_d = S_SCAN;
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    reg_wrt_en = 1'b0;
    if (state_q != S_IDLE)   busy       = 1'b1;
    if (state_q == S_DONE)   done       = 1'b1;
    if (state_q == S_STROBE) reg_wrt_en = 1'b1;
  end

  // Lowest set work bit wins
  always_comb begin
    pick = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (work_q[i]) pick = 5'(i);
    end
  end

  always_comb begin
    pop = 6'd0;
    for (int i = 0; i < 32; i++) begin
      pop = pop + 6'(dirty_q[i]);
    end
    pend_d = pop[5] ? 5'd31 : pop[4:0];
  end

  always_comb begin
    dirty_d = dirty_q;
    work_d  = work_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    dat_d   = dat_q;
    err_d   = err_q;
    if (abort_hit) begin
      // Return unsent and partially sent entries to the dirty set
      dirty_d = dirty_q | work_q | cur_bit;
      work_d  = 32'd0;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (sync_edge) begin
            work_d  = dirty_q;
            dirty_d = 32'd0;
          end
        end
        S_SCAN: begin
          cnt_d = 8'd0;
          if (work_q != 32'd0) begin
            cur_d        = pick;
            work_d[pick] = 1'b0;
            off_d        = {9'd0, pick[4:3], 2'd0, pick[2:0]};
            dat_d        = shadow_q[pick];
          end
        end
        S_SETUP:  cnt_d = (cnt_q == SETUP_LAST) ? 8'd0 : cnt_q + 8'd1;
        S_STROBE: cnt_d = (cnt_q == HOLD_LAST) ? 8'd0 : cnt_q + 8'd1;
        default: ;
      endcase
    end
    if (commit_ok) err_d = 1'b0;
    // A host write landing in the snapshot cycle stays dirty for the next commit
    if (host_wr_en) begin
      if (addr_ok) dirty_d[host_addr] = 1'b1;
      else         err_d = 1'b1;
    end
  end

  always_ff @(posedge trn_clk or negedge pio_reset_n) begin
    if (!pio_reset_n) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= 32'd0;
      dirty_q <= 32'd0;
      work_q  <= 32'd0;
      cur_q   <= 5'd0;
      cnt_q   <= 8'd0;
      off_q   <= 16'd0;
      dat_q   <= 32'd0;
      err_q   <= 1'b0;
      pend_q  <= 5'd0;
    end else begin
      if (host_wr_en && addr_ok) shadow_q[host_addr] <= host_wdata;
      dirty_q <= dirty_d;
      work_q  <= work_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  assign reg_offset = off_q;
  assign reg_data   = dat_q;
  assign addr_err   = err_q;
  assign pending    = pend_q;

endmodule

// File: tb/tb_coef_commit_sequencer.sv
// Randomized scoreboard bench for coef_commit_sequencer: a shadow/dirty model predicts strobe order and content.
module tb_coef_commit_sequencer;

  localparam int NB = 3;
  localparam int NC = 6;
  localparam int SU = 2;
  localparam int WH = 2;

  logic        trn_clk = 1'b0;
  logic        pio_reset_n;
  logic        host_wr_en;
  logic [4:0]  host_addr;
  logic [31:0] host_wdata;
  logic        commit;
  logic        abort;
  logic        word_sync_n;
  logic [15:0] reg_offset;
  logic [31:0] reg_data;
  logic        reg_wrt_en;
  logic        busy;
  logic        done;
  logic        addr_err;
  logic [4:0]  pending;

  coef_commit_sequencer #(.NBANK(NB), .NCH(NC), .SETUP(SU), .WR_HOLD(WH)) dut (
    .trn_clk(trn_clk), .pio_reset_n(pio_reset_n), .host_wr_en(host_wr_en),
    .host_addr(host_addr), .host_wdata(host_wdata), .commit(commit), .abort(abort),
    .word_sync_n(word_sync_n), .reg_offset(reg_offset), .reg_data(reg_data),
    .reg_wrt_en(reg_wrt_en), .busy(busy), .done(done), .addr_err(addr_err),
    .pending(pending)
  );

  always #5 trn_clk = ~trn_clk;

  typedef struct {
    int          idx;
    logic [15:0] off;
    logic [31:0] dat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_shadow [32];
  bit          m_dirty [32];
  bit          m_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int done_base = 0;
  int snap_cyc = 0;
  int total_strobes = 0;
  int cur_idx  = 0;

  always @(posedge trn_clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit m_valid(input int a);
    return ((a / 8) < NB) && ((a % 8) < NC);
  endfunction

  function automatic int m_pending();
    int n = 0;
    for (int i = 0; i < 32; i++) n += m_dirty[i];
    return n;
  endfunction

  // Monitor: pops the scoreboard on each strobe and checks strobe shape
  exp_t mon_e;
  bit   prev_wrt = 0;
  bit   in_burst = 0;
  int   hi_run = 0;
  int   lo_run = 0;

  always @(negedge trn_clk) begin
    if (!pio_reset_n) begin
      prev_wrt = 0; in_burst = 0; hi_run = 0; lo_run = 0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("queue_empty_at_done", exp_q.size(), 0);
      end
      if (reg_wrt_en && !prev_wrt) begin
        total_strobes++;
        check("strobe_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          cur_idx = mon_e.idx;
          check("strobe_offset", reg_offset, mon_e.off);
          check("strobe_data", reg_data, mon_e.dat);
        end
        if (in_burst) check("setup_gap", lo_run, SU + 1);
        in_burst = 1;
        hi_run = 1;
      end else if (reg_wrt_en) begin
        hi_run++;
      end
      if (!reg_wrt_en && prev_wrt && busy) check("strobe_len", hi_run, WH);
      lo_run = reg_wrt_en ? 0 : lo_run + 1;
      if (!busy) in_burst = 0;
      prev_wrt = reg_wrt_en;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge trn_clk);
      #1;
    end
  endtask

  task automatic host_write(input int a, input logic [31:0] d);
    host_wr_en = 1'b1; host_addr = 5'(a); host_wdata = d;
    tick(1);
    host_wr_en = 1'b0;
    if (m_valid(a)) begin
      m_shadow[a] = d;
      m_dirty[a]  = 1;
    end else begin
      m_err = 1;
    end
  endtask

  task automatic commit_pulse();
    tick(4);
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    m_err = 0;
  endtask

  task automatic m_snapshot();
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      if (m_dirty[i]) begin
        e.idx = i;
        e.off = 16'((i / 8) * 32 + (i % 8));
        e.dat = m_shadow[i];
        exp_q.push_back(e);
        m_dirty[i] = 0;
      end
    end
  endtask

  // Falling frame sync; optional host write presented in the snapshot cycle
  task automatic sync_edge(input bit with_wr, input int a, input logic [31:0] d);
    done_base = done_cnt;
    word_sync_n = 1'b0;
    tick(2);
    if (with_wr) begin
      host_wr_en = 1'b1; host_addr = 5'(a); host_wdata = d;
    end
    tick(1);
    host_wr_en = 1'b0;
    snap_cyc = cyc;
    m_snapshot();
    if (with_wr && m_valid(a)) begin
      m_shadow[a] = d;
      m_dirty[a]  = 1;
    end
    word_sync_n = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == done_base; i++) tick(1);
    check("done_pulse_count", done_cnt - done_base, 1);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    m_dirty[cur_idx] = 1;
    foreach (exp_q[i]) m_dirty[exp_q[i].idx] = 1;
    exp_q.delete();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_shadow[i] = 32'd0;
      m_dirty[i]  = 0;
    end
    m_err = 0;
    exp_q.delete();
  endtask

  initial begin
    int base, n;
    bit found;
    pio_reset_n = 1'b0; host_wr_en = 1'b0; host_addr = 5'd0; host_wdata = 32'd0;
    commit = 1'b0; abort = 1'b0; word_sync_n = 1'b1;
    model_reset();
    tick(3);
    check("rst_offset", reg_offset, 16'd0);
    check("rst_data", reg_data, 32'd0);
    check("rst_wrt_en", reg_wrt_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr_err", addr_err, 0);
    check("rst_pending", pending, 0);
    pio_reset_n = 1'b1;
    tick(2);

    // Two-entry burst
    host_write(0, 32'h0003FF53);
    host_write(1, 32'h0003FF33);
    tick(1);
    check("pending_two", pending, m_pending());
    commit_pulse();
    check("busy_armed", busy, 1);
    sync_edge(0, 0, 32'd0);
    wait_done(40);
    tick(2);
    check("pending_after_burst", pending, m_pending());

    // Invalid addresses, then a commit with nothing dirty
    host_write(5'b11_000, $urandom);
    host_write(5'b00_110, $urandom);
    tick(1);
    check("addr_err_set", addr_err, m_err);
    check("pending_unchanged", pending, m_pending());
    commit_pulse();
    check("addr_err_cleared", addr_err, m_err);
    base = total_strobes;
    sync_edge(0, 0, 32'd0);
    wait_done(20);
    tick(2);
    check("empty_burst_strobes", total_strobes - base, 0);

    // Full 18-entry burst
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < NC; c++)
        host_write(b * 8 + c, (b == 2 && c == 4) ? 32'h386FC749 : $urandom);
    tick(1);
    check("pending_full", pending, m_pending());
    commit_pulse();
    base = total_strobes;
    sync_edge(0, 0, 32'd0);
    wait_done(150);
    check("full_burst_strobes", total_strobes - base, 18);
    check("full_burst_time", (done_cyc - snap_cyc) >= 90 && (done_cyc - snap_cyc) <= 92, 1);
    tick(1);
    check("offset_held", reg_offset, 16'h0045);
    check("data_held", reg_data, m_shadow[21]);
    check("pending_after_full", pending, m_pending());

    // Abort during the second strobe of a three-entry burst
    for (int i = 0; i < 3; i++) host_write(i, $urandom);
    commit_pulse();
    base = total_strobes;
    sync_edge(0, 0, 32'd0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick(1);
      if (total_strobes - base == 2 && reg_wrt_en) found = 1;
    end
    check("abort_window_found", found, 1);
    do_abort();
    check("abort_wrt_low", reg_wrt_en, 0);
    check("abort_idle", busy, 0);
    tick(3);
    check("abort_no_done", done_cnt, done_base);
    check("abort_pending", pending, m_pending());
    commit_pulse();
    sync_edge(0, 0, 32'd0);
    wait_done(60);

    // Host write coinciding with the snapshot edge
    host_write(0, $urandom);
    commit_pulse();
    base = total_strobes;
    sync_edge(1, 3, $urandom);
    wait_done(40);
    tick(2);
    check("snap_write_strobes", total_strobes - base, 1);
    check("snap_write_pending", pending, m_pending());
    commit_pulse();
    sync_edge(0, 0, 32'd0);
    wait_done(40);

    // Randomized bursts
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) host_write($urandom_range(0, 31), $urandom);
      tick(1);
      check("rand_addr_err", addr_err, m_err);
      check("rand_pending", pending, m_pending());
      commit_pulse();
      check("rand_err_cleared", addr_err, m_err);
      sync_edge(0, 0, 32'd0);
      wait_done(200);
      tick(2);
      check("rand_pending_after", pending, m_pending());
    end

    // Reset in the middle of a strobe
    host_write(8, $urandom);
    host_write(9, $urandom);
    host_write(5'b11_111, $urandom);
    commit_pulse();
    sync_edge(0, 0, 32'd0);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick(1);
      if (reg_wrt_en) found = 1;
    end
    check("reset_strobe_found", found, 1);
    #2 pio_reset_n = 1'b0;
    #1;
    check("reset_wrt_low", reg_wrt_en, 0);
    check("reset_busy_low", busy, 0);
    check("reset_done_low", done, 0);
    model_reset();
    tick(2);
    pio_reset_n = 1'b1;
    tick(2);
    check("reset_pending", pending, m_pending());
    check("reset_addr_err", addr_err, m_err);
    check("reset_offset", reg_offset, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
